corescore_reset_seq: RTL and testbench

- Sequences reset release for the CoreScore SoC after the clock generator.
- Runs on the generated clock. Takes the generator's raw asynchronous reset and produces two staged, synchronously released reset domains: peripherals first, then the SERV core array.
- Also provides a handshaked soft-reset request, a ready flag and a saturating soft-reset counter for debug.

---
 rtl/corescore_reset_seq.sv | 121 ++++++++++++
 tb/tb_corescore_reset_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/corescore_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : corescore_reset_seq
// Purpose  : Staged reset release (peripherals, then cores) with soft reset.
// Revision : 1.0 - initial release
// ============================================================================
module corescore_reset_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int PERIPH_DELAY  = 64,
  parameter int CORE_DELAY    = 16,
  parameter int SW_RST_CYCLES = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sw_req,
  output logic       o_sw_ack,
  output logic       o_rst_periph,
  output logic       o_rst_core,
  output logic       o_ready,
  output logic [7:0] o_sw_count
);

  localparam int c_max_pc    = (PERIPH_DELAY > CORE_DELAY) ? PERIPH_DELAY : CORE_DELAY;
  localparam int c_max_delay = (c_max_pc > SW_RST_CYCLES) ? c_max_pc : SW_RST_CYCLES;
  localparam int c_cnt_w     = (c_max_delay > 1) ? $clog2(c_max_delay) : 1;

  localparam logic [c_cnt_w-1:0] c_periph_last = c_cnt_w'(PERIPH_DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_core_last   = c_cnt_w'(CORE_DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_sw_last     = c_cnt_w'(SW_RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_HOLD_P = 3'd1,
    ST_HOLD_C = 3'd2,
    ST_RUN    = 3'd3,
    ST_SW_RST = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  // First SYNC_STAGES-1 synchronizer stages; leaving ST_SYNC acts as the last stage.
  logic [SYNC_STAGES-2:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= r_sync << 1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_SYNC;
      r_cnt        <= '0;
      o_rst_periph <= 1'b1;
      o_rst_core   <= 1'b1;
      o_ready      <= 1'b0;
      o_sw_ack     <= 1'b0;
      o_sw_count   <= 8'd0;
    end else begin
      o_sw_ack <= 1'b0;
      case (r_state)
        ST_SYNC: begin
          if (!r_sync[SYNC_STAGES-2]) begin
            r_state <= ST_HOLD_P;
            r_cnt   <= '0;
          end
        end
        ST_HOLD_P: begin
          if (r_cnt == c_periph_last) begin
            o_rst_periph <= 1'b0;
            r_cnt        <= '0;
            r_state      <= ST_HOLD_C;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        ST_HOLD_C: begin
          if (r_cnt == c_core_last) begin
            o_rst_core <= 1'b0;
            o_ready    <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_RUN;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        ST_RUN: begin
          if (i_sw_req) begin
            o_rst_periph <= 1'b1;
            o_rst_core   <= 1'b1;
            o_ready      <= 1'b0;
            o_sw_ack     <= 1'b1;
            if (o_sw_count != 8'hFF) begin
              o_sw_count <= o_sw_count + 8'd1;
            end
            r_cnt   <= '0;
            r_state <= ST_SW_RST;
          end
        end
        ST_SW_RST: begin
          // Soft reset re-enters the staged release without re-synchronizing.
          if (r_cnt == c_sw_last) begin
            r_cnt   <= '0;
            r_state <= ST_HOLD_P;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_SYNC;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_corescore_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_corescore_reset_seq
// Purpose  : Directed checks of staged release, soft reset, abort, saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_corescore_reset_seq;

  logic       clk = 1'b0;
  logic       rst, sw_req, ack, rp, rc, rdy;
  logic [7:0] cnt;
  logic       rst_s, req_s, ack_s, rp_s, rc_s, rdy_s;
  logic [7:0] cnt_s;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  corescore_reset_seq dut (
    .i_clk(clk), .i_rst(rst), .i_sw_req(sw_req), .o_sw_ack(ack),
    .o_rst_periph(rp), .o_rst_core(rc), .o_ready(rdy), .o_sw_count(cnt)
  );

  corescore_reset_seq #(.SYNC_STAGES(2), .PERIPH_DELAY(1), .CORE_DELAY(1), .SW_RST_CYCLES(1)) dut_s (
    .i_clk(clk), .i_rst(rst_s), .i_sw_req(req_s), .o_sw_ack(ack_s),
    .o_rst_periph(rp_s), .o_rst_core(rc_s), .o_ready(rdy_s), .o_sw_count(cnt_s)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_periph"}, rp, 8'd1);
    chk({tag, "_core"}, rc, 8'd1);
    chk({tag, "_ready"}, rdy, 8'd0);
    chk({tag, "_ack"}, ack, 8'd0);
    chk({tag, "_count"}, cnt, 8'd0);
  endtask

  // Steps n edges (k = 1..n); periph falls at edge pf, core/ready at edge cf.
  // A one-cycle request pulse is sampled at edge req_at (0 = none).
  task automatic check_seq(input int n, input int pf, input int cf, input int exp_cnt, input int req_at);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      chk($sformatf("periph@%0d", k), rp, {7'd0, (k < pf)});
      chk($sformatf("core@%0d", k), rc, {7'd0, (k < cf)});
      chk($sformatf("ready@%0d", k), rdy, {7'd0, (k >= cf)});
      chk($sformatf("ack@%0d", k), ack, 8'd0);
      chk($sformatf("count@%0d", k), cnt, 8'(exp_cnt));
      sw_req = (k + 1 == req_at);
    end
  endtask

  task automatic soft_req(input int exp_cnt);
    sw_req = 1'b1;
    @(posedge clk); #1;
    chk("sw_ack", ack, 8'd1);
    chk("sw_periph", rp, 8'd1);
    chk("sw_core", rc, 8'd1);
    chk("sw_ready", rdy, 8'd0);
    chk("sw_count", cnt, 8'(exp_cnt));
    sw_req = 1'b0;
  endtask

  initial begin
    int e;
    rst = 1'b0; sw_req = 1'b0; rst_s = 1'b0; req_s = 1'b0;
    #1 rst = 1'b1; rst_s = 1'b1;
    #1 chk_reset_vals("por");

    // Power-on release plus an ignored request during HOLD_C (edge 70).
    @(negedge clk) rst = 1'b0;
    check_seq(100, 66, 82, 0, 70);

    // Soft reset: periph released 96 edges later, core 16 after that.
    soft_req(1);
    check_seq(115, 96, 112, 1, 0);

    // Second soft reset aborted by async reset between edges 90 and 91.
    soft_req(2);
    check_seq(90, 96, 112, 2, 0);
    #3 rst = 1'b1;
    #1 chk_reset_vals("abort");
    #2 rst = 1'b0;
    check_seq(100, 66, 82, 0, 0);

    // Saturation: request held high, acks at edges 4m+1 (m >= 1).
    req_s = 1'b1;
    @(negedge clk) rst_s = 1'b0;
    e = 0;
    for (int k = 1; k <= 1203; k++) begin
      @(posedge clk); #1;
      if (k >= 5 && (k % 4) == 1) e++;
      chk($sformatf("sat_ack@%0d", k), ack_s, {7'd0, (k >= 5 && (k % 4) == 1)});
      chk($sformatf("sat_count@%0d", k), cnt_s, 8'((e > 255) ? 255 : e));
    end
    chk("sat_final", cnt_s, 8'd255);

    // Random requests and resets; ordering invariants on both instances.
    for (int k = 0; k < 10000; k++) begin
      @(posedge clk); #1;
      chk("inv_order", {7'd0, (rc === 1'b0 && rp === 1'b1)}, 8'd0);
      chk("inv_ready", rdy, {7'd0, ~rc});
      chk("inv_order_s", {7'd0, (rc_s === 1'b0 && rp_s === 1'b1)}, 8'd0);
      chk("inv_ready_s", rdy_s, {7'd0, ~rc_s});
      sw_req = 1'($urandom_range(0, 1));
      req_s  = 1'($urandom_range(0, 1));
      rst    = ($urandom_range(0, 299) == 0);
      rst_s  = ($urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
